// File: rtl/pll_lock_reset_seq_if.sv
// Signal bundle between the PLL lock/reset sequencer (slave) and the logic that
// feeds it lock status and software controls (master).
interface pll_lock_reset_seq_if #(
    parameter int NUM_DOMAINS = 4,
    parameter int CNT_W       = 8
);
    logic                   locked_in;
    logic                   sw_rst;
    logic                   clr_sticky;
    logic [NUM_DOMAINS-1:0] domain_rst_out;
    logic                   all_ready;
    logic [1:0]             state_out;
    logic [CNT_W-1:0]       lock_loss_cnt;
    logic                   lock_lost_sticky;

    modport master (
        output locked_in, sw_rst, clr_sticky,
        input  domain_rst_out, all_ready, state_out, lock_loss_cnt, lock_lost_sticky
    );

    modport slave (
        input  locked_in, sw_rst, clr_sticky,
        output domain_rst_out, all_ready, state_out, lock_loss_cnt, lock_lost_sticky
    );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// Synchronizes and filters PLL LOCKED, then releases per-domain resets one by one.
// Optional lock-loss counter and sticky flag are built when PLL_LOCK_LOSS_CNT_EN is defined.
module pll_lock_reset_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int STAGE_DELAY = 8,
    parameter int NUM_DOMAINS = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clkin_int,
    input  logic                reset_active,
    pll_lock_reset_seq_if.slave bus
);
    localparam int FLT_W = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int DLY_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_sync_s;
    logic                   loss_evt_s;
    logic                   go_wait_s;
    state_e                 state_q, state_d;
    logic [FLT_W-1:0]       filt_q, filt_d;
    logic [DLY_W-1:0]       dly_q, dly_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic                   ready_q, ready_d;

    // Lock synchronizer: locked_in enters stage 0, locked_sync is the last stage
    always_ff @(posedge clkin_int or posedge reset_active) begin
        if (reset_active) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked_in};
        end
    end

    assign locked_sync_s = sync_q[SYNC_STAGES-1];

    // Losing lock only counts once resets have started to release; a filter dropout is benign.
    assign loss_evt_s = ((state_q == RELEASE) || (state_q == RUN)) && !locked_sync_s;
    assign go_wait_s  = loss_evt_s
                      || ((state_q != WAIT_LOCK) && bus.sw_rst)
                      || ((state_q == FILTER) && !locked_sync_s);

    // Next-state and output decode for the lock/release sequencer
    always_comb begin
        state_d   = state_q;
        filt_d    = filt_q;
        dly_d     = dly_q;
        idx_d     = idx_q;
        dom_rst_d = dom_rst_q;
        ready_d   = ready_q;
        if (go_wait_s) begin
            state_d   = WAIT_LOCK;
            filt_d    = {FLT_W{1'b0}};
            dly_d     = {DLY_W{1'b0}};
            idx_d     = {IDX_W{1'b0}};
            dom_rst_d = {NUM_DOMAINS{1'b1}};
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    filt_d = {FLT_W{1'b0}};
                    if (locked_sync_s) begin
                        state_d = FILTER;
                    end else begin
                        state_d = WAIT_LOCK;
                    end
                end
                FILTER: begin
                    if (filt_q == FLT_LAST) begin
                        state_d = RELEASE;
                        filt_d  = {FLT_W{1'b0}};
                        dly_d   = {DLY_W{1'b0}};
                        idx_d   = {IDX_W{1'b0}};
                    end else begin
                        filt_d = filt_q + FLT_W'(1);
                    end
                end
                RELEASE: begin
                    if (dly_q == DLY_LAST) begin
                        dly_d            = {DLY_W{1'b0}};
                        dom_rst_d[idx_q] = 1'b0;
                        idx_d            = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        dly_d = dly_q + DLY_W'(1);
                    end
                end
                RUN: begin
                    state_d   = RUN;
                    dom_rst_d = {NUM_DOMAINS{1'b0}};
                    ready_d   = 1'b1;
                end
                default: begin
                    state_d   = WAIT_LOCK;
                    dom_rst_d = {NUM_DOMAINS{1'b1}};
                    ready_d   = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered reset outputs
    always_ff @(posedge clkin_int or posedge reset_active) begin
        if (reset_active) begin
            state_q   <= WAIT_LOCK;
            filt_q    <= {FLT_W{1'b0}};
            dly_q     <= {DLY_W{1'b0}};
            idx_q     <= {IDX_W{1'b0}};
            dom_rst_q <= {NUM_DOMAINS{1'b1}};
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            filt_q    <= filt_d;
            dly_q     <= dly_d;
            idx_q     <= idx_d;
            dom_rst_q <= dom_rst_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.domain_rst_out = dom_rst_q;
    assign bus.all_ready      = ready_q;
    assign bus.state_out      = state_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic             sticky_q, sticky_d;

    // Saturating loss count; a loss event beats a coincident sticky clear
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        sticky_d   = sticky_q;
        if (loss_evt_s) begin
            sticky_d = 1'b1;
            if (loss_cnt_q != {CNT_W{1'b1}}) begin
                loss_cnt_d = loss_cnt_q + CNT_W'(1);
            end else begin
                loss_cnt_d = loss_cnt_q;
            end
        end else if (bus.clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Lock-loss statistics registers, cleared only by reset_active
    always_ff @(posedge clkin_int or posedge reset_active) begin
        if (reset_active) begin
            loss_cnt_q <= {CNT_W{1'b0}};
            sticky_q   <= 1'b0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    assign bus.lock_loss_cnt    = loss_cnt_q;
    assign bus.lock_lost_sticky = sticky_q;
`else
    logic unused_clr_sticky_s;
    assign unused_clr_sticky_s  = bus.clr_sticky;
    assign bus.lock_loss_cnt    = {CNT_W{1'b0}};
    assign bus.lock_lost_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Scoreboard bench for pll_lock_reset_seq: stimulus queues edge-tagged expectations,
// a monitor compares them at the falling edge after the tagged rising edge.
module tb_pll_lock_reset_seq;
    localparam int ND = 4;
    localparam int CW = 8;
`ifdef PLL_LOCK_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        int            cyc;
        logic [ND-1:0] rst;
        logic          rdy;
        logic [1:0]    st;
        logic [CW-1:0] cnt;
        logic          sticky;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    logic clkin_int = 1'b0;
    logic reset_active;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;
    bit   model_sticky = 1'b0;
    event chk_now;

    pll_lock_reset_seq_if #(.NUM_DOMAINS(ND), .CNT_W(CW)) bus ();

    pll_lock_reset_seq #(
        .SYNC_STAGES(2), .LOCK_FILTER(16), .STAGE_DELAY(8), .NUM_DOMAINS(ND), .CNT_W(CW)
    ) dut (
        .clkin_int    (clkin_int),
        .reset_active (reset_active),
        .bus          (bus)
    );

    always #5 clkin_int = ~clkin_int;

    always @(posedge clkin_int) edge_n <= edge_n + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clkin_int);
    endtask

    task automatic wait_to(input int target);
        while (edge_n < target) @(negedge clkin_int);
    endtask

    task automatic expect_at(input int cyc, input string nm, input logic [ND-1:0] rst,
                             input logic rdy, input logic [1:0] st);
        exp_t e;
        e.cyc    = cyc;
        e.rst    = rst;
        e.rdy    = rdy;
        e.st     = st;
        e.cnt    = CNT_EN ? CW'(model_cnt) : {CW{1'b0}};
        e.sticky = CNT_EN ? model_sticky : 1'b0;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic expect_now(input string nm, input logic [ND-1:0] rst, input logic rdy,
                              input logic [1:0] st);
        expect_at(-1, nm, rst, rdy, st);
        -> chk_now;
    endtask

    task automatic note_loss();
        model_cnt    = (model_cnt < (2 ** CW) - 1) ? model_cnt + 1 : (2 ** CW) - 1;
        model_sticky = 1'b1;
    endtask

    // From WAIT_LOCK with a cleared synchronizer: raise lock and walk through to RUN.
    task automatic run_up(input string p);
        int b;
        b = edge_n;
        bus.locked_in = 1'b1;
        expect_at(b + 1,  {p, "_idle"},      4'b1111, 1'b0, 2'd0);
        expect_at(b + 2,  {p, "_sync"},      4'b1111, 1'b0, 2'd0);
        expect_at(b + 3,  {p, "_filter"},    4'b1111, 1'b0, 2'd1);
        expect_at(b + 18, {p, "_filt_end"},  4'b1111, 1'b0, 2'd1);
        expect_at(b + 19, {p, "_release"},   4'b1111, 1'b0, 2'd2);
        expect_at(b + 26, {p, "_b0_hold"},   4'b1111, 1'b0, 2'd2);
        expect_at(b + 27, {p, "_b0"},        4'b1110, 1'b0, 2'd2);
        expect_at(b + 35, {p, "_b1"},        4'b1100, 1'b0, 2'd2);
        expect_at(b + 43, {p, "_b2"},        4'b1000, 1'b0, 2'd2);
        expect_at(b + 50, {p, "_b3_hold"},   4'b1000, 1'b0, 2'd2);
        expect_at(b + 51, {p, "_run"},       4'b0000, 1'b1, 2'd3);
        wait_to(b + 51);
    endtask

    // One lock-loss event caught early in RELEASE; optionally clr_sticky in the same cycle.
    task automatic loss_event(input bit clr_c);
        int n;
        n = edge_n;
        bus.locked_in = 1'b1;
        expect_at(n + 19, "loss_in_release", 4'b1111, 1'b0, 2'd2);
        wait_to(n + 19);
        bus.locked_in = 1'b0;
        wait_to(n + 21);
        bus.clr_sticky = clr_c;
        note_loss();
        expect_at(n + 22, clr_c ? "loss_clr_coinc" : "loss_event", 4'b1111, 1'b0, 2'd0);
        wait_to(n + 22);
        bus.clr_sticky = 1'b0;
    endtask

    // Scoreboard monitor: pops every expectation whose edge has arrived
    initial begin
        forever begin
            @(negedge clkin_int or chk_now);
            while (exp_q.size() > 0 && (exp_q[0].cyc < 0 || exp_q[0].cyc <= edge_n)) begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (bus.domain_rst_out !== e.rst || bus.all_ready !== e.rdy ||
                    bus.state_out !== e.st || bus.lock_loss_cnt !== e.cnt ||
                    bus.lock_lost_sticky !== e.sticky) begin
                    errors++;
                    $display("FAIL %s edge=%0d: got rst=%b rdy=%b st=%0d cnt=%0d sticky=%b, want rst=%b rdy=%b st=%0d cnt=%0d sticky=%b",
                             nm, edge_n, bus.domain_rst_out, bus.all_ready, bus.state_out,
                             bus.lock_loss_cnt, bus.lock_lost_sticky,
                             e.rst, e.rdy, e.st, e.cnt, e.sticky);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        logic [CW-1:0] sat_exp;
        reset_active   = 1'b1;
        bus.locked_in  = 1'b0;
        bus.sw_rst     = 1'b0;
        bus.clr_sticky = 1'b0;
        tick(2);
        #1;
        expect_now("reset_state", 4'b1111, 1'b0, 2'd0);
        checks++;
        if (bus.domain_rst_out !== 4'b1111 || bus.state_out !== 2'd0) begin
            errors++;
            $display("FAIL direct_reset: got rst=%b st=%0d, want rst=1111 st=0",
                     bus.domain_rst_out, bus.state_out);
        end

        // Short lock (10 cycles) aborts in FILTER without a loss event
        tick(1);
        reset_active  = 1'b0;
        bus.locked_in = 1'b1;
        n = edge_n;
        expect_at(n + 10, "short_filter", 4'b1111, 1'b0, 2'd1);
        expect_at(n + 12, "short_still",  4'b1111, 1'b0, 2'd1);
        expect_at(n + 13, "short_abort",  4'b1111, 1'b0, 2'd0);
        wait_to(n + 10);
        bus.locked_in = 1'b0;
        wait_to(n + 13);

        run_up("seq");

        // Lock loss in RUN
        n = edge_n;
        bus.locked_in = 1'b0;
        expect_at(n + 2, "loss_run_hold", 4'b0000, 1'b1, 2'd3);
        note_loss();
        expect_at(n + 3, "loss_run", 4'b1111, 1'b0, 2'd0);
        wait_to(n + 3);

        // 299 more events (300 total) saturate the count; last one has clr_sticky coincident
        for (int i = 0; i < 299; i++) begin
            loss_event(i == 298);
        end
        bus.clr_sticky = 1'b1;
        model_sticky = 1'b0;
        expect_at(edge_n + 1, "sticky_clear", 4'b1111, 1'b0, 2'd0);
        tick(1);
        bus.clr_sticky = 1'b0;
        sat_exp = CNT_EN ? {CW{1'b1}} : {CW{1'b0}};
        checks++;
        if (bus.lock_loss_cnt !== sat_exp || bus.lock_lost_sticky !== 1'b0) begin
            errors++;
            $display("FAIL direct_saturate: got cnt=%0d sticky=%b, want cnt=%0d sticky=0",
                     bus.lock_loss_cnt, bus.lock_lost_sticky, sat_exp);
        end

        run_up("rerun");

        // Software reset in RUN: not a loss event, full re-sequence follows
        n = edge_n;
        bus.sw_rst = 1'b1;
        expect_at(n + 1,  "swrst_wait",    4'b1111, 1'b0, 2'd0);
        expect_at(n + 2,  "swrst_filter",  4'b1111, 1'b0, 2'd1);
        expect_at(n + 19, "swrst_release", 4'b1111, 1'b0, 2'd2);
        expect_at(n + 49, "swrst_b3_hold", 4'b1000, 1'b0, 2'd2);
        expect_at(n + 50, "swrst_run",     4'b0000, 1'b1, 2'd3);
        tick(1);
        bus.sw_rst = 1'b0;
        wait_to(n + 50);

        // Async reset mid-RELEASE at 1100
        n = edge_n;
        bus.sw_rst = 1'b1;
        expect_at(n + 34, "pre_rst_b1",  4'b1100, 1'b0, 2'd2);
        expect_at(n + 36, "pre_rst_b1b", 4'b1100, 1'b0, 2'd2);
        tick(1);
        bus.sw_rst = 1'b0;
        wait_to(n + 36);
        #2;
        reset_active = 1'b1;
        #1;
        checks++;
        if (bus.domain_rst_out !== 4'b1111 || bus.state_out !== 2'd0) begin
            errors++;
            $display("FAIL direct_async_reset: got rst=%b st=%0d, want rst=1111 st=0",
                     bus.domain_rst_out, bus.state_out);
        end
        model_cnt    = 0;
        model_sticky = 1'b0;
        expect_now("async_reset", 4'b1111, 1'b0, 2'd0);
        tick(1);
        #1;
        expect_now("reset_hold", 4'b1111, 1'b0, 2'd0);
        tick(1);
        reset_active = 1'b0;
        run_up("post_rst");
        tick(2);

        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no check, want check at edge %0d", name_q[0], exp_q[0].cyc);
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
